fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 160 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: issues sequential instruction reads to a 1-cycle-latency
// memory and forwards returned words, in program order, into an instruction
// FIFO. A 2-entry skid buffer absorbs the response already in flight when the
// FIFO fills, and branch redirects discard every word from the old stream.
module fetch_sequencer #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_SIZE  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  branch_valid,
  input  logic [ADDR_WIDTH-1:0] branch_address,
  input  logic                  fifo_full,
  input  logic                  mem_r_valid,
  input  logic [DATA_SIZE-1:0]  mem_r_data,
  output logic                  mem_r_en,
  output logic [ADDR_WIDTH-1:0] mem_r_adrs,
  output logic                  fifo_w_en,
  output logic [DATA_SIZE-1:0]  fifo_w_data,
  output logic                  protocol_err
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, FLUSH} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc, pc_d;
  logic                   inflight_q;
  logic                   drop_q, drop_d;
  logic [1:0]             skid_count, skid_count_d;
  logic [DATA_SIZE-1:0]   skid_data_0, skid_data_0_d;
  logic [DATA_SIZE-1:0]   skid_data_1, skid_data_1_d;
  logic                   protocol_err_d;

  logic [2:0]             occupancy;
  logic                   issue_ok;
  logic                   branch_take;
  logic                   resp;
  logic                   resp_keep;
  logic                   spurious;

  // Skid entries plus the read in flight must never exceed the buffer depth,
  // so every response that cannot go straight to the FIFO has a slot waiting.
  assign occupancy   = {1'b0, skid_count} + {2'b00, inflight_q};
  assign issue_ok    = !rst && !fifo_full && (occupancy < 3'd2) && !branch_valid
                       && (state_q != IDLE);
  assign branch_take = branch_valid && (state_q != IDLE);
  assign resp        = mem_r_valid && inflight_q;
  assign resp_keep   = resp && !drop_q;
  assign spurious    = mem_r_valid && !inflight_q;

  // Next-state, response routing and output strobes.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc;
    drop_d         = drop_q;
    skid_count_d   = skid_count;
    skid_data_0_d  = skid_data_0;
    skid_data_1_d  = skid_data_1;
    protocol_err_d = protocol_err | spurious;
    mem_r_en       = issue_ok;
    mem_r_adrs     = pc;
    fifo_w_en      = 1'b0;
    fifo_w_data    = '0;

    if (branch_take) begin
      // Redirect wins over everything. With single-cycle latency the old
      // stream's in-flight word lands in this very cycle and is not pushed;
      // drop_q records that a flush cycle is owed before the new stream.
      pc_d         = branch_address;
      skid_count_d = 2'd0;
      drop_d       = inflight_q;
      state_d      = inflight_q ? FLUSH : RUN;
    end else begin
      if (issue_ok) begin
        pc_d = pc + ADDR_WIDTH'(1);
      end

      if (resp && drop_q) begin
        drop_d = 1'b0;
      end
      // Nothing from the old stream can still be outstanding once FLUSH is
      // reached, so the discard flag retires here and the new stream's first
      // response (issued this cycle) is kept.
      if (state_q == FLUSH) begin
        drop_d = 1'b0;
      end

      if (!fifo_full && skid_count != 2'd0) begin
        // Oldest buffered word goes first; a same-cycle response queues behind.
        fifo_w_en   = 1'b1;
        fifo_w_data = skid_data_0;
        if (skid_count == 2'd2) begin
          skid_data_0_d = skid_data_1;
          if (resp_keep) begin
            skid_data_1_d = mem_r_data;
          end else begin
            skid_count_d = 2'd1;
          end
        end else begin
          if (resp_keep) begin
            skid_data_0_d = mem_r_data;
          end else begin
            skid_count_d = 2'd0;
          end
        end
      end else if (!fifo_full && resp_keep) begin
        fifo_w_en   = 1'b1;
        fifo_w_data = mem_r_data;
      end else if (resp_keep) begin
        if (skid_count == 2'd0) begin
          skid_data_0_d = mem_r_data;
          skid_count_d  = 2'd1;
        end else begin
          skid_data_1_d = mem_r_data;
          skid_count_d  = 2'd2;
        end
      end

      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = issue_ok ? RUN : HOLD;
        HOLD:    state_d = issue_ok ? RUN : HOLD;
        FLUSH:   state_d = issue_ok ? RUN : HOLD;
        default: state_d = IDLE;
      endcase
    end

    if (rst) begin
      mem_r_en    = 1'b0;
      fifo_w_en   = 1'b0;
      fifo_w_data = '0;
    end
  end

  // Control registers; reset abandons any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc           <= '0;
      inflight_q   <= 1'b0;
      drop_q       <= 1'b0;
      skid_count   <= 2'd0;
      protocol_err <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc           <= pc_d;
      inflight_q   <= mem_r_en;
      drop_q       <= drop_d;
      skid_count   <= skid_count_d;
      protocol_err <= protocol_err_d;
    end
  end

  // Skid data storage; validity is carried by skid_count alone.
  always_ff @(posedge clk) begin
    skid_data_0 <= skid_data_0_d;
    skid_data_1 <= skid_data_1_d;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized bench with a 1-cycle memory responder and a
// scoreboard of expected FIFO words (consecutive addresses, restarting at
// each branch target).
module tb_fetch_sequencer;
  localparam int AW = 11;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          branch_valid = 1'b0;
  logic [AW-1:0] branch_address = '0;
  logic          fifo_full = 1'b0;
  logic          mem_r_valid = 1'b0;
  logic [DW-1:0] mem_r_data = '0;
  logic          mem_r_en;
  logic [AW-1:0] mem_r_adrs;
  logic          fifo_w_en;
  logic [DW-1:0] fifo_w_data;
  logic          protocol_err;

  int            checks = 0;
  int            errors = 0;
  int            pushes = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_req = '0;
  bit            mon_en = 1'b0;
  bit            pend_v = 1'b0;
  logic [AW-1:0] pend_a = '0;
  bit            spur = 1'b0;

  fetch_sequencer #(.ADDR_WIDTH(AW), .DATA_SIZE(DW)) dut (
    .clk(clk), .rst(rst), .branch_valid(branch_valid),
    .branch_address(branch_address), .fifo_full(fifo_full),
    .mem_r_valid(mem_r_valid), .mem_r_data(mem_r_data),
    .mem_r_en(mem_r_en), .mem_r_adrs(mem_r_adrs), .fifo_w_en(fifo_w_en),
    .fifo_w_data(fifo_w_data), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    return DW'(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Expected instruction stream restarts at a new address.
  task automatic set_stream(input logic [AW-1:0] a);
    exp_q.delete();
    for (int i = 0; i < 96; i++) exp_q.push_back(word(AW'(int'(a) + i)));
    exp_req = a;
  endtask

  // Memory answers one cycle after a request with word = address.
  task automatic tick();
    @(posedge clk);
    #1;
    mem_r_valid = pend_v | spur;
    mem_r_data  = pend_v ? word(pend_a) : 32'hDEAD_BEEF;
  endtask

  task automatic step(input bit r, input bit full, input bit br,
                      input logic [AW-1:0] tgt, input bit taken);
    tick();
    rst = r;
    fifo_full = full;
    branch_valid = br;
    branch_address = tgt;
    if (br && taken) set_stream(tgt);
    @(negedge clk);
  endtask

  task automatic wait_req(input logic [AW-1:0] a, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 1'b0, 1'b0, '0, 1'b0);
      if (mem_r_en && mem_r_adrs == a) found = 1'b1;
    end
    check(name, 64'(found), 64'(1));
  endtask

  task automatic wait_push(input logic [AW-1:0] a, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step(1'b0, 1'b0, 1'b0, '0, 1'b0);
      if (fifo_w_en) begin
        found = 1'b1;
        check(name, 64'(fifo_w_data), 64'(word(a)));
      end
    end
    if (!found) check({name, "_seen"}, 64'(0), 64'(1));
  endtask

  // Monitor: captures requests for the memory model and scores every push.
  initial begin
    logic [DW-1:0] exp_w;
    forever begin
      @(negedge clk);
      pend_v = mem_r_en;
      pend_a = mem_r_adrs;
      if (mon_en) begin
        if (fifo_w_en) begin
          pushes++;
          check("push_while_full", 64'(fifo_full), 64'(0));
          if (exp_q.size() == 0) begin
            check("sb_underflow", 64'(fifo_w_data), 64'(0) - 64'(1));
          end else begin
            exp_w = exp_q.pop_front();
            check("sb_word", 64'(fifo_w_data), 64'(exp_w));
          end
        end
        if (mem_r_en) begin
          check("req_adrs", 64'(mem_r_adrs), 64'(exp_req));
          check("req_blocked", 64'(fifo_full | branch_valid), 64'(0));
          exp_req = AW'(int'(exp_req) + 1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time budget exceeded, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Stimulus and directed checks.
  initial begin
    bit full;
    int len;
    logic [AW-1:0] tgt;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    check("rst_mem_r_en", 64'(mem_r_en), 64'(0));
    check("rst_fifo_w_en", 64'(fifo_w_en), 64'(0));
    check("rst_fifo_w_data", 64'(fifo_w_data), 64'(0));
    check("rst_protocol_err", 64'(protocol_err), 64'(0));

    // Release; a branch while still IDLE must be ignored.
    set_stream('0);
    mon_en = 1'b1;
    step(1'b0, 1'b0, 1'b1, 11'h333, 1'b0);
    check("idle_no_req", 64'(mem_r_en), 64'(0));
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("first_req_en", 64'(mem_r_en), 64'(1));
    check("first_req_adrs", 64'(mem_r_adrs), 64'(0));
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("first_push_en", 64'(fifo_w_en), 64'(1));
    check("first_push_data", 64'(fifo_w_data), 64'(0));
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, '0, 1'b0);
      check("throughput", 64'({fifo_w_en, mem_r_en}), 64'(3));
    end

    // FIFO full for five cycles, then the skid drains in order.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, '0, 1'b0);
      check("no_push_full", 64'(fifo_w_en), 64'(0));
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b0, '0, 1'b0);
      check("drain_push", 64'(fifo_w_en), 64'(1));
    end

    // Branch to 0x100 while the read of 0x020 is in flight.
    step(1'b0, 1'b0, 1'b1, 11'h01C, 1'b1);
    wait_req(11'h020, "reach_020");
    step(1'b0, 1'b0, 1'b1, 11'h100, 1'b1);
    check("br_no_push", 64'(fifo_w_en), 64'(0));
    check("br_no_req", 64'(mem_r_en), 64'(0));
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("flush_issue", 64'({mem_r_en, mem_r_adrs}), 64'({1'b1, 11'h100}));
    check("flush_drop", 64'(fifo_w_en), 64'(0));
    wait_push(11'h100, "post_branch_word");

    // Address wrap.
    step(1'b0, 1'b0, 1'b1, 11'h7FD, 1'b1);
    wait_req(11'h7FF, "reach_7ff");
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("wrap_req", 64'({mem_r_en, mem_r_adrs}), 64'({1'b1, 11'h000}));

    // Back-to-back branches: last target wins.
    step(1'b0, 1'b0, 1'b1, 11'h010, 1'b1);
    step(1'b0, 1'b0, 1'b1, 11'h040, 1'b1);
    wait_push(11'h040, "b2b_word");

    // Randomized segments: a branch, then random back-pressure.
    for (int seg = 0; seg < 60; seg++) begin
      tgt = ($urandom_range(0, 3) == 0) ? AW'(11'h7F8 + $urandom_range(0, 7))
                                        : AW'($urandom);
      step(1'b0, ($urandom_range(0, 2) == 0), 1'b1, tgt, 1'b1);
      if ($urandom_range(0, 5) == 0)
        step(1'b0, 1'b0, 1'b1, AW'($urandom), 1'b1);
      len = $urandom_range(4, 40);
      for (int i = 0; i < len; i++) begin
        full = ($urandom_range(0, 99) < 35);
        step(1'b0, full, 1'b0, '0, 1'b0);
      end
    end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("push_volume", 64'(pushes > 200), 64'(1));

    // Reset mid-stream, then a spurious response right after release.
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    check("midrst_outputs", 64'({mem_r_en, fifo_w_en, fifo_w_data}), 64'(0));
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    check("midrst_perr", 64'(protocol_err), 64'(0));
    set_stream('0);
    spur = 1'b1;
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    spur = 1'b0;
    check("spur_no_push", 64'(fifo_w_en), 64'(0));
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("perr_set", 64'(protocol_err), 64'(1));
    check("spur_req0", 64'({mem_r_en, mem_r_adrs}), 64'({1'b1, 11'h000}));
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("perr_sticky", 64'(protocol_err), 64'(1));
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    check("perr_cleared", 64'(protocol_err), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
